// File: rtl/banco_reg_param.sv
// banco_reg_param: parametrised register file with two asynchronous read
// ports, one synchronous write port, synchronous clear and a per-register
// busy scoreboard (reserve at decode, release on writeback).
// Optional macro BANCO_REG_BYPASS_EN forwards same-cycle write data (and the
// resulting busy state) to a read port addressing the register being written.
module banco_reg_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned N_REGS   = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] r_a,
  input  logic [ADDR_W-1:0] r_b,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              reserve_enable,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              any_busy
);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_d;

  logic wr_ok;
  logic rs_ok;

  // A write or reserve only acts on an implemented, writable register.
  assign wr_ok = write_enable && (32'(write_addr) < N_REGS) &&
                 !((ZERO_REG != 0) && (write_addr == '0));
  assign rs_ok = reserve_enable && (32'(reserve_addr) < N_REGS) &&
                 !((ZERO_REG != 0) && (reserve_addr == '0));

  // Next state: write clears busy, reserve applied after so it wins on a tie.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (wr_ok && (32'(write_addr) == i)) begin
        regs_d[i] = write_data;
        busy_d[i] = 1'b0;
      end
      if (rs_ok && (32'(reserve_addr) == i)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // State registers with synchronous clear taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

`ifdef BANCO_REG_BYPASS_EN
  logic wr_fwd;
  logic rs_same;
  assign wr_fwd  = wr_ok && !rst;
  assign rs_same = rs_ok && (reserve_addr == write_addr);
`endif

  // Read port A: unimplemented addresses and a hardwired register 0 read as 0.
  always_comb begin
    a      = '0;
    busy_a = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if ((32'(r_a) == i) && !((ZERO_REG != 0) && (i == 0))) begin
        a      = regs_q[i];
        busy_a = busy_q[i];
      end
    end
`ifdef BANCO_REG_BYPASS_EN
    if (wr_fwd && (r_a == write_addr)) begin
      a      = write_data;
      busy_a = rs_same;
    end
`endif
  end

  // Read port B: same selection as port A.
  always_comb begin
    b      = '0;
    busy_b = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if ((32'(r_b) == i) && !((ZERO_REG != 0) && (i == 0))) begin
        b      = regs_q[i];
        busy_b = busy_q[i];
      end
    end
`ifdef BANCO_REG_BYPASS_EN
    if (wr_fwd && (r_b == write_addr)) begin
      b      = write_data;
      busy_b = rs_same;
    end
`endif
  end

  assign any_busy = |busy_q;

endmodule

// File: tb/tb_banco_reg_param.sv
module tb_banco_reg_param;

`ifdef BANCO_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT 0: default parameters
  logic       we0, re0;
  logic [1:0] wa0, ra0, rda0, rdb0;
  logic [7:0] wd0, a0, b0;
  logic       ba0, bb0, any0;

  banco_reg_param #(.DATA_W(8), .N_REGS(4), .ADDR_W(2), .ZERO_REG(0)) u_d0 (
    .clk(clk), .rst(rst), .write_enable(we0), .write_addr(wa0), .write_data(wd0),
    .r_a(rda0), .r_b(rdb0), .a(a0), .b(b0), .reserve_enable(re0), .reserve_addr(ra0),
    .busy_a(ba0), .busy_b(bb0), .any_busy(any0));

  // DUT 1: hardwired zero register, 16-bit, 8 registers
  logic        we1, re1;
  logic [2:0]  wa1, ra1, rda1, rdb1;
  logic [15:0] wd1, a1, b1;
  logic        ba1, bb1, any1;

  banco_reg_param #(.DATA_W(16), .N_REGS(8), .ADDR_W(3), .ZERO_REG(1)) u_d1 (
    .clk(clk), .rst(rst), .write_enable(we1), .write_addr(wa1), .write_data(wd1),
    .r_a(rda1), .r_b(rdb1), .a(a1), .b(b1), .reserve_enable(re1), .reserve_addr(ra1),
    .busy_a(ba1), .busy_b(bb1), .any_busy(any1));

  // DUT 2: partially populated address space
  logic       we2, re2;
  logic [2:0] wa2, ra2, rda2, rdb2;
  logic [7:0] wd2, a2, b2;
  logic       ba2, bb2, any2;

  banco_reg_param #(.DATA_W(8), .N_REGS(5), .ADDR_W(3), .ZERO_REG(0)) u_d2 (
    .clk(clk), .rst(rst), .write_enable(we2), .write_addr(wa2), .write_data(wd2),
    .r_a(rda2), .r_b(rdb2), .a(a2), .b(b2), .reserve_enable(re2), .reserve_addr(ra2),
    .busy_a(ba2), .busy_b(bb2), .any_busy(any2));

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [1:0] ra;
    logic [1:0] rd_a;
    logic [1:0] rd_b;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eba;
    logic       ebb;
    logic       eany;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle_all();
    we0 = 1'b0; re0 = 1'b0; wa0 = '0; ra0 = '0; wd0 = '0;
    we1 = 1'b0; re1 = 1'b0; wa1 = '0; ra1 = '0; wd1 = '0;
    we2 = 1'b0; re2 = 1'b0; wa2 = '0; ra2 = '0; wd2 = '0;
  endtask

  // Clock edge, then drop strobes so sampled outputs show stored state only.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    we0 = 1'b0; re0 = 1'b0;
    we1 = 1'b0; re1 = 1'b0;
    we2 = 1'b0; re2 = 1'b0;
    #1;
  endtask

  initial begin
    //                rst   we    wa    wd     re    ra    rda   rdb   ea     eb     eba   ebb   eany
    vt[0]  = '{1'b0, 1'b1, 2'd2, 8'hAA, 1'b0, 2'd0, 2'd2, 2'd2, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 2'd2, 8'h55, 1'b1, 2'd2, 2'd2, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 2'd3, 8'h5C, 1'b0, 2'd0, 2'd3, 2'd3, 8'h5C, 8'h5C, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 2'd3, 8'h00, 8'h5C, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd1, 2'd0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 2'd2, 8'h7F, 1'b1, 2'd2, 2'd2, 2'd1, 8'h7F, 8'h11, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 2'd0, 8'h42, 1'b1, 2'd1, 2'd0, 2'd1, 8'h42, 8'h11, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 2'd2, 2'd1, 8'h33, 8'h11, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 2'd1, 8'h99, 1'b0, 2'd0, 2'd1, 2'd3, 8'h99, 8'h5C, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd2, 8'h42, 8'h33, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd0, 8'h5C, 8'h42, 1'b1, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b1, 2'd1, 8'hEE, 1'b1, 2'd1, 2'd3, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    idle_all();
    rda0 = '0; rdb0 = '0; rda1 = '0; rdb1 = '0; rda2 = '0; rdb2 = '0;
    rst = 1'b1;
    @(negedge clk);
    step();
    for (int i = 0; i < 4; i++) begin
      rda0 = 2'(i);
      rdb0 = 2'(3 - i);
      #1;
      chk($sformatf("reset a[%0d]", i), 32'(a0), 32'h0);
      chk($sformatf("reset b[%0d]", 3 - i), 32'(b0), 32'h0);
    end
    chk("reset any_busy", 32'(any0), 32'h0);

    // Table of single-cycle operations on the default-parameter instance
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst  = vt[i].rst;
      we0  = vt[i].we;   wa0 = vt[i].wa; wd0 = vt[i].wd;
      re0  = vt[i].re;   ra0 = vt[i].ra;
      rda0 = vt[i].rd_a; rdb0 = vt[i].rd_b;
      step();
      chk($sformatf("v%0d a", i), 32'(a0), 32'(vt[i].ea));
      chk($sformatf("v%0d b", i), 32'(b0), 32'(vt[i].eb));
      chk($sformatf("v%0d busy_a", i), 32'(ba0), 32'(vt[i].eba));
      chk($sformatf("v%0d busy_b", i), 32'(bb0), 32'(vt[i].ebb));
      chk($sformatf("v%0d any_busy", i), 32'(any0), 32'(vt[i].eany));
    end

    // Read during write: register 3 holds 0 after the last reset
    @(negedge clk);
    we0 = 1'b1; wa0 = 2'd3; wd0 = 8'hC3; rda0 = 2'd3; rdb0 = 2'd0;
    #1;
    chk("rdw before edge a", 32'(a0), BYP ? 32'hC3 : 32'h0);
    chk("rdw before edge b", 32'(b0), 32'h0);
    chk("rdw before edge busy_a", 32'(ba0), 32'h0);
    @(posedge clk);
    #1;
    chk("rdw after edge a", 32'(a0), 32'hC3);
    // Write plus reserve of the same register in one cycle
    @(negedge clk);
    we0 = 1'b1; wa0 = 2'd3; wd0 = 8'h77; re0 = 1'b1; ra0 = 2'd3;
    #1;
    chk("wr+rsv before edge a", 32'(a0), BYP ? 32'h77 : 32'hC3);
    chk("wr+rsv before edge busy_a", 32'(ba0), BYP ? 32'h1 : 32'h0);
    step();
    chk("wr+rsv after a", 32'(a0), 32'h77);
    chk("wr+rsv after busy_a", 32'(ba0), 32'h1);
    chk("wr+rsv after any_busy", 32'(any0), 32'h1);

    // Hardwired zero register instance (reset by vt[12])
    @(negedge clk);
    we1 = 1'b1; wa1 = 3'd0; wd1 = 16'hBEEF; re1 = 1'b1; ra1 = 3'd0;
    rda1 = 3'd0; rdb1 = 3'd0;
    #1;
    chk("zr before edge a", 32'(a1), 32'h0);
    step();
    chk("zr a", 32'(a1), 32'h0);
    chk("zr busy_a", 32'(ba1), 32'h0);
    chk("zr any_busy", 32'(any1), 32'h0);
    @(negedge clk);
    we1 = 1'b1; wa1 = 3'd7; wd1 = 16'h1234; rda1 = 3'd7; rdb1 = 3'd0;
    step();
    chk("zr r7 a", 32'(a1), 32'h1234);
    chk("zr r0 b", 32'(b1), 32'h0);
    @(negedge clk);
    re1 = 1'b1; ra1 = 3'd7; rdb1 = 3'd7;
    step();
    chk("zr r7 busy_b", 32'(bb1), 32'h1);
    chk("zr any_busy set", 32'(any1), 32'h1);

    // Partially populated instance: out-of-range write/reserve
    @(negedge clk);
    we2 = 1'b1; wa2 = 3'd4; wd2 = 8'h44;
    step();
    @(negedge clk);
    we2 = 1'b1; wa2 = 3'd6; wd2 = 8'hFF; re2 = 1'b1; ra2 = 3'd6;
    rda2 = 3'd6; rdb2 = 3'd2;
    step();
    chk("oor a(6)", 32'(a2), 32'h0);
    chk("oor busy_a(6)", 32'(ba2), 32'h0);
    chk("oor any_busy", 32'(any2), 32'h0);
    chk("oor no alias r2", 32'(b2), 32'h0);
    rda2 = 3'd4; rdb2 = 3'd5;
    #1;
    chk("oor r4 kept", 32'(a2), 32'h44);
    chk("oor read 5", 32'(b2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
